// File: rtl/contador_pkg.sv
// Shared constants for the contador counter-chain controller: FSM encodings,
// default digit moduli and the prioritised command code.
package contador_pkg;

    localparam int LO_MOD_DEF = 12;
    localparam int HI_MOD_DEF = 11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_STOP,
        CMD_LOAD,
        CMD_START,
        CMD_PAUSE,
        CMD_STEP
    } cmd_t;

endpackage

// File: rtl/contador_digito.sv
// One modulus-MOD digit: synchronous load, wrap-around increment and a
// combinational carry that enables the next digit in the chain.
module contador_digito #(
    parameter int W   = 4,
    parameter int MOD = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] Q_MAX = W'(MOD - 1);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (ld) begin
            q_reg <= d;
        end else if (en) begin
            q_reg <= (q_reg == Q_MAX) ? '0 : q_reg + 1'b1;
        end
    end

    assign q     = q_reg;
    assign carry = en && (q_reg == Q_MAX);

endmodule

// File: rtl/contador_ctrl.sv
// Run/pause/step/load controller for the cascaded low/high counter pair,
// with one-shot stop at a target and match/wrap/done/err event pulses.
module contador_ctrl
    import contador_pkg::*;
#(
    parameter int W      = 4,
    parameter int LO_MOD = LO_MOD_DEF,
    parameter int HI_MOD = HI_MOD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_lo,
    input  logic [W-1:0] load_hi,
    input  logic [W-1:0] target_lo,
    input  logic [W-1:0] target_hi,
    input  logic         one_shot,
    output logic [W-1:0] cnt_lo,
    output logic [W-1:0] cnt_hi,
    output logic         busy,
    output logic         done,
    output logic         match,
    output logic         wrap,
    output logic         err,
    output logic [2:0]   state
);

    localparam logic [W-1:0] LO_MAX = W'(LO_MOD - 1);
    localparam logic [W-1:0] HI_MAX = W'(HI_MOD - 1);

    logic [2:0]   state_reg, state_next;
    logic         done_reg, match_reg, wrap_reg, err_reg;
    logic         done_next, match_next, err_next;
    logic         adv, clr, ld_ok, load_valid, hit;
    logic         carry_lo, carry_hi;
    logic [W-1:0] nxt_lo, nxt_hi, d_lo, d_hi;
    cmd_t         cmd;

    always_comb begin
        if (stop)       cmd = CMD_STOP;
        else if (load)  cmd = CMD_LOAD;
        else if (start) cmd = CMD_START;
        else if (pause) cmd = CMD_PAUSE;
        else if (step)  cmd = CMD_STEP;
        else            cmd = CMD_NONE;
    end

    assign load_valid = (int'(load_lo) < LO_MOD) && (int'(load_hi) < HI_MOD);

    // Count value after one advance; an out-of-range target can never equal it.
    assign nxt_lo = (cnt_lo == LO_MAX) ? '0 : cnt_lo + 1'b1;
    assign nxt_hi = (cnt_lo != LO_MAX) ? cnt_hi :
                    (cnt_hi == HI_MAX) ? '0 : cnt_hi + 1'b1;
    assign hit    = (nxt_lo == target_lo) && (nxt_hi == target_hi);

    always_comb begin
        state_next = state_reg;
        adv        = 1'b0;
        clr        = 1'b0;
        ld_ok      = 1'b0;
        err_next   = 1'b0;
        case (cmd)
            CMD_STOP: begin
                state_next = ST_IDLE;
                clr        = 1'b1;
            end
            CMD_LOAD: begin
                if (state_reg == ST_RUN) begin
                    adv = tick;
                end else if (load_valid) begin
                    ld_ok = 1'b1;
                    if (state_reg == ST_DONE) state_next = ST_IDLE;
                end else begin
                    err_next = 1'b1;
                end
            end
            CMD_START: begin
                if (state_reg == ST_RUN) adv = tick;
                else                     state_next = ST_RUN;
            end
            CMD_PAUSE: begin
                if (state_reg == ST_RUN) state_next = ST_PAUSE;
            end
            CMD_STEP: begin
                if (state_reg == ST_PAUSE)    adv = 1'b1;
                else if (state_reg == ST_RUN) adv = tick;
            end
            default: begin
                if (state_reg == ST_RUN) adv = tick;
            end
        endcase
        match_next = adv && hit;
        done_next  = match_next && one_shot;
        if (done_next) state_next = ST_DONE;
    end

    assign d_lo = clr ? '0 : load_lo;
    assign d_hi = clr ? '0 : load_hi;

    contador_digito #(.W(W), .MOD(LO_MOD)) u_lo (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .ld    (clr || ld_ok),
        .d     (d_lo),
        .q     (cnt_lo),
        .carry (carry_lo)
    );

    contador_digito #(.W(W), .MOD(HI_MOD)) u_hi (
        .clk   (clk),
        .rst   (rst),
        .en    (carry_lo),
        .ld    (clr || ld_ok),
        .d     (d_hi),
        .q     (cnt_hi),
        .carry (carry_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
            match_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            match_reg <= match_next;
            wrap_reg  <= carry_hi;
            err_reg   <= err_next;
        end
    end

    assign busy  = (state_reg == ST_RUN);
    assign done  = done_reg;
    assign match = match_reg;
    assign wrap  = wrap_reg;
    assign err   = err_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_contador_ctrl.sv
// Self-checking bench for contador_ctrl: directed scenarios plus randomized
// commands, compared every cycle against a linear-count behavioural model.
module tb_contador_ctrl;

    localparam int LO    = 12;
    localparam int HI    = 11;
    localparam int TOTAL = LO * HI;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic       step = 1'b0, load = 1'b0, one_shot = 1'b0;
    logic [3:0] load_lo = 4'd0, load_hi = 4'd0;
    logic [3:0] target_lo = 4'd15, target_hi = 4'd15;
    logic [3:0] cnt_lo, cnt_hi;
    logic       busy, done, match, wrap, err;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int wraps, advs;

    // Model: count kept as a single integer hi*LO+lo, state as 0..3.
    int m_cnt = 0;
    int m_st  = 0;
    bit m_done, m_match, m_wrap, m_err;

    contador_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .step      (step),
        .load      (load),
        .load_lo   (load_lo),
        .load_hi   (load_hi),
        .target_lo (target_lo),
        .target_hi (target_hi),
        .one_shot  (one_shot),
        .cnt_lo    (cnt_lo),
        .cnt_hi    (cnt_hi),
        .busy      (busy),
        .done      (done),
        .match     (match),
        .wrap      (wrap),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit adv;
        bit tgt_ok;
        int tgt;
        adv     = 1'b0;
        m_done  = 1'b0;
        m_match = 1'b0;
        m_wrap  = 1'b0;
        m_err   = 1'b0;
        if (!rst) begin
            m_st  = 0;
            m_cnt = 0;
            return;
        end
        tgt_ok = (int'(target_lo) < LO) && (int'(target_hi) < HI);
        tgt    = int'(target_hi) * LO + int'(target_lo);
        if (stop) begin
            m_st  = 0;
            m_cnt = 0;
        end else if (load) begin
            if (m_st == 1) begin
                adv = tick;
            end else if (int'(load_lo) < LO && int'(load_hi) < HI) begin
                m_cnt = int'(load_hi) * LO + int'(load_lo);
                if (m_st == 3) m_st = 0;
            end else begin
                m_err = 1'b1;
            end
        end else if (start) begin
            if (m_st == 1) adv = tick;
            else           m_st = 1;
        end else if (pause) begin
            if (m_st == 1) m_st = 2;
        end else if (step) begin
            if (m_st == 2)      adv = 1'b1;
            else if (m_st == 1) adv = tick;
        end else if (m_st == 1) begin
            adv = tick;
        end
        if (adv) begin
            m_cnt  = (m_cnt + 1) % TOTAL;
            m_wrap = (m_cnt == 0);
            if (tgt_ok && m_cnt == tgt) begin
                m_match = 1'b1;
                if (one_shot) begin
                    m_st   = 3;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic clk_cycle();
        model_update();
        @(posedge clk);
        #1;
        chk("cnt_lo", cnt_lo, m_cnt % LO);
        chk("cnt_hi", cnt_hi, m_cnt / LO);
        chk("state",  state,  m_st);
        chk("busy",   busy,   m_st == 1);
        chk("done",   done,   m_done);
        chk("match",  match,  m_match);
        chk("wrap",   wrap,   m_wrap);
        chk("err",    err,    m_err);
        if (wrap) wraps++;
    endtask

    initial begin
        // Reset and reset mid-RUN at (5,3)
        repeat (2) clk_cycle();
        rst = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_cnt", {cnt_hi, cnt_lo}, 0);
        start = 1'b1; tick = 1'b1;
        clk_cycle();
        start = 1'b0;
        repeat (41) clk_cycle();
        chk("t1_lo", cnt_lo, 5);
        chk("t1_hi", cnt_hi, 3);
        rst = 1'b0;
        clk_cycle();
        rst = 1'b1; tick = 1'b0;
        chk("t1_state", state, 0);
        chk("t1_cnt", {cnt_hi, cnt_lo}, 0);
        chk("t1_pulses", {busy, done, match, wrap, err}, 0);
        $display("scenario reset-mid-run complete");

        // Free run through a full chain cycle
        start = 1'b1; tick = 1'b1;
        clk_cycle();
        start = 1'b0; wraps = 0;
        repeat (11) clk_cycle();
        chk("t2_11_0", {cnt_hi, cnt_lo}, {4'd0, 4'd11});
        clk_cycle();
        chk("t2_0_1", {cnt_hi, cnt_lo}, {4'd1, 4'd0});
        repeat (120) clk_cycle();
        chk("t2_wraps", wraps, 1);
        chk("t2_wrap_now", wrap, 1);
        chk("t2_cnt", {cnt_hi, cnt_lo}, 0);
        tick = 1'b0;
        $display("scenario free-run complete");

        // Preset at the wrap point, then rejected preset
        stop = 1'b1; clk_cycle(); stop = 1'b0;
        load = 1'b1; load_lo = 4'd11; load_hi = 4'd10; clk_cycle(); load = 1'b0;
        chk("t3_preset", {cnt_hi, cnt_lo}, {4'd10, 4'd11});
        start = 1'b1; clk_cycle(); start = 1'b0;
        tick = 1'b1; clk_cycle(); tick = 1'b0;
        chk("t3_wrap", wrap, 1);
        chk("t3_cnt", {cnt_hi, cnt_lo}, 0);
        pause = 1'b1; clk_cycle(); pause = 1'b0;
        load = 1'b1; load_lo = 4'd12; load_hi = 4'd3; clk_cycle(); load = 1'b0;
        chk("t3_err", err, 1);
        chk("t3_hold", {cnt_hi, cnt_lo}, 0);
        $display("scenario load-wrap-reject complete");

        // One-shot stop at (3,2)
        stop = 1'b1; clk_cycle(); stop = 1'b0;
        one_shot = 1'b1; target_lo = 4'd3; target_hi = 4'd2;
        start = 1'b1; clk_cycle(); start = 1'b0;
        tick = 1'b1; advs = 0;
        for (int i = 0; i < 200; i++) begin
            clk_cycle();
            advs++;
            if (done) break;
        end
        chk("t4_advs", advs, 27);
        chk("t4_done_match", {done, match}, 2'b11);
        repeat (3) clk_cycle();
        chk("t4_hold", {cnt_hi, cnt_lo}, {4'd2, 4'd3});
        chk("t4_state", state, 3);
        tick = 1'b0; one_shot = 1'b0; target_lo = 4'd15; target_hi = 4'd15;
        $display("scenario one-shot complete");

        // Pause and single steps with tick low
        stop = 1'b1; clk_cycle(); stop = 1'b0;
        load = 1'b1; load_lo = 4'd4; load_hi = 4'd0; clk_cycle(); load = 1'b0;
        start = 1'b1; clk_cycle(); start = 1'b0;
        chk("t5_run", state, 1);
        pause = 1'b1; clk_cycle(); pause = 1'b0;
        step = 1'b1; repeat (3) clk_cycle(); step = 1'b0;
        chk("t5_cnt", {cnt_hi, cnt_lo}, {4'd0, 4'd7});
        chk("t5_state", state, 2);
        $display("scenario pause-step complete");

        // Command priority and load ignored in RUN
        start = 1'b1; clk_cycle(); start = 1'b0;
        stop = 1'b1; load = 1'b1; start = 1'b1; clk_cycle();
        stop = 1'b0; load = 1'b0; start = 1'b0;
        chk("t6_state", state, 0);
        chk("t6_cnt", {cnt_hi, cnt_lo}, 0);
        start = 1'b1; clk_cycle(); start = 1'b0;
        load = 1'b1; load_lo = 4'd5; load_hi = 4'd5; clk_cycle(); load = 1'b0;
        chk("t6_noerr", err, 0);
        chk("t6_ignored", {cnt_hi, cnt_lo}, 0);
        $display("scenario priority complete");

        // Randomized commands against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                one_shot  = 1'($urandom_range(0, 1));
                target_lo = 4'($urandom_range(0, 12));
                target_hi = 4'($urandom_range(0, 11));
            end
            rst     = ($urandom_range(0, 199) != 0);
            tick    = 1'($urandom_range(0, 1));
            stop    = ($urandom_range(0, 39) == 0);
            load    = ($urandom_range(0, 15) == 0);
            start   = ($urandom_range(0, 9) == 0);
            pause   = ($urandom_range(0, 9) == 0);
            step    = ($urandom_range(0, 3) == 0);
            load_lo = 4'($urandom_range(0, 13));
            load_hi = 4'($urandom_range(0, 12));
            clk_cycle();
        end
        $display("scenario random complete");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
